// File: rtl/inst_fetch_ctrl.sv
// Fetch-stage sequencer: owns the fetch PC, issues 1-cycle inst RAM reads,
// buffers returned words and hands {pc, pred_pc, inst} to pre-decode.
module inst_fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h1c000000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        halt,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_ram_en,
    output logic [31:0] inst_ram_addr,
    input  logic [31:0] inst_ram_r_data,
    output logic        out_valid,
    input  logic        out_allow_in,
    output logic [31:0] out_pc,
    output logic [31:0] out_pred_pc,
    output logic [31:0] out_inst
);

    localparam int unsigned PW = $clog2(BUF_DEPTH);
    localparam int unsigned OW = PW + 1;

    typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_e;

    state_e          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic            epoch_q, epoch_d;
    logic            infl_q, infl_d;
    logic            infl_epoch_q, infl_epoch_d;
    logic [31:0]     infl_pc_q, infl_pc_d;
    logic [OW-1:0]   occ_q, occ_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [31:0]     buf_pc_q   [BUF_DEPTH];
    logic [31:0]     buf_inst_q [BUF_DEPTH];

    logic [31:0]     redir_pc_al;
    logic [31:0]     fetch_addr;
    logic [31:0]     occ_sum;
    logic            credit_ok;
    logic            req;
    logic            push;
    logic            pop;
    logic            has_head;
    logic            head_valid;
    logic            unused_redir_lsb;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_BOOT;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_BOOT:  state_d = S_RUN;
            S_RUN:   if (halt)  state_d = S_HALT;
            S_HALT:  if (!halt) state_d = S_RUN;
            default: state_d = S_BOOT;
        endcase
    end

    // Datapath: request/credit, buffer bookkeeping and PC tracking
    always_comb begin
        unused_redir_lsb = ^redirect_pc[1:0];
        redir_pc_al = {redirect_pc[31:2], 2'b00};
        fetch_addr  = reset ? RESET_PC : (redirect_valid ? redir_pc_al : fetch_pc_q);
        has_head    = !reset && (occ_q != '0);
        head_valid  = has_head && !redirect_valid;
        pop         = head_valid && out_allow_in;
        // A redirect discards both the buffer and the in-flight slot, so credit restarts at zero.
        occ_sum     = redirect_valid ? '0 : (32'(occ_q) + 32'(infl_q) - 32'(pop));
        credit_ok   = occ_sum < BUF_DEPTH;
        req         = !reset && (state_q == S_RUN) && !halt && credit_ok;
        push        = infl_q && (infl_epoch_q == epoch_q) && !redirect_valid;

        fetch_pc_d = fetch_pc_q;
        if (req)                 fetch_pc_d = fetch_addr + 32'd4;
        else if (redirect_valid) fetch_pc_d = redir_pc_al;

        epoch_d      = epoch_q ^ redirect_valid;
        infl_d       = req;
        infl_epoch_d = epoch_d;
        infl_pc_d    = fetch_addr;

        if (redirect_valid) begin
            occ_d    = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            occ_d    = occ_q + OW'(push) - OW'(pop);
            rd_ptr_d = rd_ptr_q + PW'(pop);
            wr_ptr_d = wr_ptr_q + PW'(push);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q   <= RESET_PC;
            epoch_q      <= 1'b0;
            infl_q       <= 1'b0;
            infl_epoch_q <= 1'b0;
            infl_pc_q    <= '0;
            occ_q        <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            epoch_q      <= epoch_d;
            infl_q       <= infl_d;
            infl_epoch_q <= infl_epoch_d;
            infl_pc_q    <= infl_pc_d;
            occ_q        <= occ_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
        end
    end

    // Entry storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc_q[wr_ptr_q]   <= infl_pc_q;
            buf_inst_q[wr_ptr_q] <= inst_ram_r_data;
        end
    end

    // Output logic
    always_comb begin
        inst_ram_en   = req;
        inst_ram_addr = fetch_addr;
        out_valid     = head_valid;
        out_pc        = has_head ? buf_pc_q[rd_ptr_q] : '0;
        out_pred_pc   = has_head ? (buf_pc_q[rd_ptr_q] + 32'd4) : '0;
        out_inst      = has_head ? buf_inst_q[rd_ptr_q] : '0;
    end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl: streaming, stalls, redirects, halt and reset.
module tb_inst_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic        halt;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_ram_en;
    logic [31:0] inst_ram_addr;
    logic [31:0] inst_ram_r_data;
    logic        out_valid;
    logic        out_allow_in;
    logic [31:0] out_pc;
    logic [31:0] out_pred_pc;
    logic [31:0] out_inst;

    int          errors;
    int          checks;
    logic [31:0] acc [$];

    inst_fetch_ctrl #(.RESET_PC(32'h1c000000), .BUF_DEPTH(2)) dut (
        .clk(clk), .reset(reset), .halt(halt),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_ram_en(inst_ram_en), .inst_ram_addr(inst_ram_addr),
        .inst_ram_r_data(inst_ram_r_data),
        .out_valid(out_valid), .out_allow_in(out_allow_in),
        .out_pc(out_pc), .out_pred_pc(out_pred_pc), .out_inst(out_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk)
        inst_ram_r_data <= inst_ram_en ? (inst_ram_addr ^ 32'hFFFF0000) : 32'h0BAD0BAD;

    // Accepted-instruction monitor and overflow guard
    always @(negedge clk) begin
        if (out_valid && out_allow_in) begin
            acc.push_back(out_pc);
            checks++;
            if (out_inst !== (out_pc ^ 32'hFFFF0000) || out_pred_pc !== out_pc + 32'd4) begin
                errors++;
                $display("FAIL mon_data pc=%h inst=%h pred=%h", out_pc, out_inst, out_pred_pc);
            end
        end
        if (!reset && dut.push && !dut.pop && dut.occ_q == 2'd2) begin
            errors++;
            $display("FAIL overflow occ=%0d push with full buffer", dut.occ_q);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (inst_ram_en !== 1'b0) begin errors++; $display("FAIL rst_en got=%b exp=0", inst_ram_en); end
        checks++; if (inst_ram_addr !== 32'h1c000000) begin errors++; $display("FAIL rst_addr got=%h exp=1c000000", inst_ram_addr); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
        checks++; if (out_pc !== 32'h0 || out_pred_pc !== 32'h0 || out_inst !== 32'h0) begin errors++; $display("FAIL rst_out got=%h/%h/%h exp=0/0/0", out_pc, out_pred_pc, out_inst); end
        step(); reset = 1'b0; #1;
        checks++; if (inst_ram_en !== 1'b0) begin errors++; $display("FAIL boot_en got=%b exp=0", inst_ram_en); end
    endtask

    task automatic test_stream();
        step(); #1;
        checks++; if (inst_ram_en !== 1'b1 || inst_ram_addr !== 32'h1c000000) begin errors++; $display("FAIL s_req0 got=%b/%h exp=1/1c000000", inst_ram_en, inst_ram_addr); end
        step(); #1;
        checks++; if (inst_ram_addr !== 32'h1c000004 || out_valid !== 1'b0) begin errors++; $display("FAIL s_req1 got=%h/%b exp=1c000004/0", inst_ram_addr, out_valid); end
        step(); #1;
        checks++; if (inst_ram_addr !== 32'h1c000008 || out_valid !== 1'b1) begin errors++; $display("FAIL s_req2 got=%h/%b exp=1c000008/1", inst_ram_addr, out_valid); end
        checks++; if (out_pc !== 32'h1c000000 || out_pred_pc !== 32'h1c000004 || out_inst !== 32'he3ff0000) begin errors++; $display("FAIL s_head0 got=%h/%h/%h exp=1c000000/1c000004/e3ff0000", out_pc, out_pred_pc, out_inst); end
        step(); #1;
        checks++; if (out_pc !== 32'h1c000004 || out_inst !== 32'he3ff0004 || inst_ram_addr !== 32'h1c00000c) begin errors++; $display("FAIL s_head1 got=%h/%h/%h exp=1c000004/e3ff0004/1c00000c", out_pc, out_inst, inst_ram_addr); end
    endtask

    task automatic test_stall();
        step(); out_allow_in = 1'b0; #1;
        checks++; if (inst_ram_en !== 1'b0 || out_pc !== 32'h1c000008) begin errors++; $display("FAIL st_first got=%b/%h exp=0/1c000008", inst_ram_en, out_pc); end
        for (int i = 0; i < 5; i++) begin
            step(); #1;
            checks++;
            if (inst_ram_en !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'h1c000008 ||
                out_inst !== 32'he3ff0008 || dut.occ_q !== 2'd2) begin
                errors++;
                $display("FAIL st_hold%0d got=en%b v%b pc%h inst%h occ%0d exp=en0 v1 pc1c000008 inste3ff0008 occ2",
                         i, inst_ram_en, out_valid, out_pc, out_inst, dut.occ_q);
            end
        end
        step(); out_allow_in = 1'b1; #1;
        checks++; if (inst_ram_en !== 1'b1 || inst_ram_addr !== 32'h1c000010 || out_pc !== 32'h1c000008) begin errors++; $display("FAIL st_rel got=%b/%h/%h exp=1/1c000010/1c000008", inst_ram_en, inst_ram_addr, out_pc); end
        step(); #1;
        checks++; if (out_pc !== 32'h1c00000c) begin errors++; $display("FAIL st_next got=%h exp=1c00000c", out_pc); end
        step(); #1;
        checks++; if (out_pc !== 32'h1c000010) begin errors++; $display("FAIL st_next2 got=%h exp=1c000010", out_pc); end
        checks++; if (acc[$] !== 32'h1c00000c || acc[$-1] !== 32'h1c000008 || acc[$-2] !== 32'h1c000004) begin errors++; $display("FAIL st_seq got=%h,%h,%h exp=1c000004,1c000008,1c00000c", acc[$-2], acc[$-1], acc[$]); end
    endtask

    task automatic test_redirect_full();
        step(); out_allow_in = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h1c000100; #1;
        checks++; if (dut.occ_q !== 2'd1 || dut.infl_q !== 1'b1) begin errors++; $display("FAIL rf_pre got=occ%0d infl%b exp=occ1 infl1", dut.occ_q, dut.infl_q); end
        checks++; if (out_valid !== 1'b0 || inst_ram_en !== 1'b1 || inst_ram_addr !== 32'h1c000100) begin errors++; $display("FAIL rf_cyc got=%b/%b/%h exp=0/1/1c000100", out_valid, inst_ram_en, inst_ram_addr); end
        step(); redirect_valid = 1'b0; out_allow_in = 1'b1; #1;
        checks++; if (out_valid !== 1'b0 || inst_ram_addr !== 32'h1c000104) begin errors++; $display("FAIL rf_gap got=%b/%h exp=0/1c000104", out_valid, inst_ram_addr); end
        step(); #1;
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h1c000100 || out_inst !== 32'he3ff0100) begin errors++; $display("FAIL rf_first got=%b/%h/%h exp=1/1c000100/e3ff0100", out_valid, out_pc, out_inst); end
        step(); #1;
        checks++; if (out_pc !== 32'h1c000104) begin errors++; $display("FAIL rf_second got=%h exp=1c000104", out_pc); end
        checks++; if (acc[$] !== 32'h1c000100 || acc[$-1] !== 32'h1c000010) begin errors++; $display("FAIL rf_seq got=%h,%h exp=1c000010,1c000100", acc[$-1], acc[$]); end
    endtask

    task automatic test_redirect_pop();
        step(); redirect_valid = 1'b1; redirect_pc = 32'h1c000008; #1;
        checks++; if (inst_ram_addr !== 32'h1c000008 || out_valid !== 1'b0) begin errors++; $display("FAIL rp_r1 got=%h/%b exp=1c000008/0", inst_ram_addr, out_valid); end
        step(); redirect_valid = 1'b0; #1;
        step(); #1;
        step(); #1;
        step(); redirect_valid = 1'b1; redirect_pc = 32'h1c000203; #1;
        checks++; if (out_pc !== 32'h1c000010) begin errors++; $display("FAIL rp_head got=%h exp=1c000010", out_pc); end
        checks++; if (out_valid !== 1'b0 || inst_ram_en !== 1'b1 || inst_ram_addr !== 32'h1c000200) begin errors++; $display("FAIL rp_r2 got=%b/%b/%h exp=0/1/1c000200", out_valid, inst_ram_en, inst_ram_addr); end
        step(); redirect_valid = 1'b0; #1;
        checks++; if (out_valid !== 1'b0 || inst_ram_addr !== 32'h1c000204) begin errors++; $display("FAIL rp_gap got=%b/%h exp=0/1c000204", out_valid, inst_ram_addr); end
        step(); #1;
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h1c000200 || out_inst !== 32'he3ff0200) begin errors++; $display("FAIL rp_first got=%b/%h/%h exp=1/1c000200/e3ff0200", out_valid, out_pc, out_inst); end
        step(); #1;
        checks++; if (acc[$] !== 32'h1c000200 || acc[$-1] !== 32'h1c00000c) begin errors++; $display("FAIL rp_seq got=%h,%h exp=1c00000c,1c000200", acc[$-1], acc[$]); end
    endtask

    task automatic test_halt();
        step(); out_allow_in = 1'b0; #1;
        step(); halt = 1'b1; out_allow_in = 1'b1; #1;
        checks++; if (inst_ram_en !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'h1c000208) begin errors++; $display("FAIL h_first got=%b/%b/%h exp=0/1/1c000208", inst_ram_en, out_valid, out_pc); end
        step(); #1;
        checks++; if (inst_ram_en !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'h1c00020c) begin errors++; $display("FAIL h_drain got=%b/%b/%h exp=0/1/1c00020c", inst_ram_en, out_valid, out_pc); end
        step(); redirect_valid = 1'b1; redirect_pc = 32'h1c000300; #1;
        checks++; if (inst_ram_en !== 1'b0 || out_valid !== 1'b0 || inst_ram_addr !== 32'h1c000300) begin errors++; $display("FAIL h_redir got=%b/%b/%h exp=0/0/1c000300", inst_ram_en, out_valid, inst_ram_addr); end
        step(); redirect_valid = 1'b0; #1;
        checks++; if (inst_ram_en !== 1'b0) begin errors++; $display("FAIL h_idle got=%b exp=0", inst_ram_en); end
        step(); halt = 1'b0; #1;
        checks++; if (inst_ram_en !== 1'b0 || inst_ram_addr !== 32'h1c000300) begin errors++; $display("FAIL h_exit got=%b/%h exp=0/1c000300", inst_ram_en, inst_ram_addr); end
        step(); #1;
        checks++; if (inst_ram_en !== 1'b1 || inst_ram_addr !== 32'h1c000300) begin errors++; $display("FAIL h_resume got=%b/%h exp=1/1c000300", inst_ram_en, inst_ram_addr); end
        step(); #1;
        checks++; if (acc[$] !== 32'h1c00020c || acc[$-1] !== 32'h1c000208) begin errors++; $display("FAIL h_seq got=%h,%h exp=1c000208,1c00020c", acc[$-1], acc[$]); end
        step(); #1;
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h1c000300) begin errors++; $display("FAIL h_first_out got=%b/%h exp=1/1c000300", out_valid, out_pc); end
    endtask

    task automatic test_reset_mid();
        step(); out_allow_in = 1'b0; reset = 1'b1; #1;
        checks++; if (inst_ram_en !== 1'b0 || out_valid !== 1'b0 || inst_ram_addr !== 32'h1c000000) begin errors++; $display("FAIL rm_in got=%b/%b/%h exp=0/0/1c000000", inst_ram_en, out_valid, inst_ram_addr); end
        step(); reset = 1'b0; out_allow_in = 1'b1; #1;
        checks++; if (out_valid !== 1'b0 || inst_ram_en !== 1'b0 || out_pc !== 32'h0) begin errors++; $display("FAIL rm_boot got=%b/%b/%h exp=0/0/0", out_valid, inst_ram_en, out_pc); end
        step(); #1;
        checks++; if (inst_ram_en !== 1'b1 || inst_ram_addr !== 32'h1c000000 || out_valid !== 1'b0) begin errors++; $display("FAIL rm_req got=%b/%h/%b exp=1/1c000000/0", inst_ram_en, inst_ram_addr, out_valid); end
        step(); #1;
        checks++; if (out_valid !== 1'b0 || inst_ram_addr !== 32'h1c000004) begin errors++; $display("FAIL rm_gap got=%b/%h exp=0/1c000004", out_valid, inst_ram_addr); end
        step(); #1;
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h1c000000 || out_inst !== 32'he3ff0000) begin errors++; $display("FAIL rm_first got=%b/%h/%h exp=1/1c000000/e3ff0000", out_valid, out_pc, out_inst); end
        step(); #1;
        checks++; if (out_pc !== 32'h1c000004 || acc[$] !== 32'h1c000000 || acc[$-1] !== 32'h1c000300) begin errors++; $display("FAIL rm_seq got=%h,%h,%h exp=1c000300,1c000000,1c000004", acc[$-1], acc[$], out_pc); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset = 1'b1;
        halt = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        out_allow_in = 1'b1;
        step();
        step();
        test_reset();
        test_stream();
        test_stall();
        test_redirect_full();
        test_redirect_pop();
        test_halt();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
